// File: rtl/query_patch_packer.sv
// query_patch_packer
//   Packs a valid/ready stream of DATA_WIDTH-bit query elements into
//   PATCH_SIZE-element patch words. It writes each patch to memory port 0 at
//   sequential addresses 0..NUM_PATCHES-1 and then reports done.
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              1-cycle pulse; starts a frame from IDLE or DONE
//   in_valid/in_data   element stream input
//   in_ready           element accepted when in_valid & in_ready
//   csb0, web0         memory chip select / write enable (active-low)
//   addr0, wpatch0     memory write address / packed patch (element 0 in LSBs)
//   busy, done         status (FILL|WRITE, DONE)
//   patch_count        number of patches written this frame
module query_patch_packer #(
  parameter int DATA_WIDTH  = 11,
  parameter int PATCH_SIZE  = 5,
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_PATCHES = 494
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic                           csb0,
  output logic                           web0,
  output logic [ADDR_WIDTH-1:0]          addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH:0]            patch_count
);
  localparam int PW    = DATA_WIDTH * PATCH_SIZE;
  localparam int IDX_W = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  elem_idx;
  logic [PW-1:0]     partial, partial_nx;
  logic              accept, last_elem, frame_start, last_patch;

  assign accept      = in_valid & in_ready;
  assign last_elem   = accept && (elem_idx == IDX_W'(PATCH_SIZE-1));
  assign frame_start = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_patch  = (patch_count == (ADDR_WIDTH+1)'(NUM_PATCHES-1));

  // One element slot per generate instance; only the slot matching
  // elem_idx takes the incoming element.
  for (genvar k = 0; k < PATCH_SIZE; k++) begin : g_slot
    assign partial_nx[k*DATA_WIDTH +: DATA_WIDTH] =
      (accept && (elem_idx == IDX_W'(k))) ? in_data
                                          : partial[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FILL;
      S_FILL:  if (last_elem) state_nx = S_WRITE;
      S_WRITE: state_nx = last_patch ? S_DONE : S_FILL;
      S_DONE:  if (start) state_nx = S_FILL;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      elem_idx    <= '0;
      partial     <= '0;
      in_ready    <= 1'b0;
      csb0        <= 1'b1;
      web0        <= 1'b1;
      addr0       <= '0;
      wpatch0     <= '0;
      patch_count <= '0;
    end else begin
      state    <= state_nx;
      // Strobes are registered from the next state so they line up exactly
      // with the FILL / WRITE cycles.
      in_ready <= (state_nx == S_FILL);
      csb0     <= (state_nx != S_WRITE);
      web0     <= (state_nx != S_WRITE);

      if (accept) begin
        elem_idx <= last_elem ? '0 : elem_idx + IDX_W'(1);
        partial  <= last_elem ? '0 : partial_nx;
      end

      // Address and data load on WRITE entry and hold afterwards.
      if (last_elem) begin
        wpatch0 <= partial_nx;
        addr0   <= patch_count[ADDR_WIDTH-1:0];
      end

      if (state == S_WRITE) patch_count <= patch_count + 1'b1;

      if (frame_start) begin
        patch_count <= '0;
        elem_idx    <= '0;
        partial     <= '0;
      end
    end
  end

  assign busy = (state == S_FILL) || (state == S_WRITE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_query_patch_packer.sv
module tb_query_patch_packer;
  localparam int DW = 11, PS = 5, AW = 9, NP = 494;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready, csb0, web0, busy, done;
  logic [AW-1:0]     addr0;
  logic [DW*PS-1:0]  wpatch0;
  logic [AW:0]       patch_count;

  int tests = 0, fails = 0;

  logic [AW-1:0]    wr_addr[$];
  logic [DW*PS-1:0] wr_data[$];
  logic             wr_rdy[$];

  query_patch_packer #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .ADDR_WIDTH(AW), .NUM_PATCHES(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .csb0(csb0), .web0(web0), .addr0(addr0), .wpatch0(wpatch0),
    .busy(busy), .done(done), .patch_count(patch_count));

  always #5 clk = ~clk;

  // Capture every write cycle, mid-cycle.
  always @(negedge clk)
    if (!csb0 && !web0) begin
      wr_addr.push_back(addr0);
      wr_data.push_back(wpatch0);
      wr_rdy.push_back(in_ready);
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*PS-1:0] pack(input int base);
    logic [DW*PS-1:0] p = '0;
    for (int k = 0; k < PS; k++) p[k*DW +: DW] = DW'(base + k);
    return p;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; repeat (n) begin @(posedge clk); #1; end rst_n = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit acc = 0;
    int budget = 100;
    in_valid = 1'b1; in_data = d;
    while (!acc && budget > 0) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      budget--;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int budget = 50;
    while (wr_addr.size() < n && budget > 0) begin @(negedge clk); budget--; end
    chk("write_seen", 64'(wr_addr.size() >= n), 1);
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_rdy.delete();
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    do_reset(2);
    @(negedge clk);
    chk("rst_csb0", csb0, 1);
    chk("rst_web0", web0, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_patch_count", patch_count, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_wpatch0", wpatch0, 0);
    @(posedge clk); #1;

    // Single patch; start and in_valid together in IDLE must not accept.
    clear_log();
    start = 1'b1; in_valid = 1'b1; in_data = 11'd77;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) send(DW'(i));
    wait_writes(1);
    chk("single_addr", wr_addr[0], 0);
    chk("single_data", wr_data[0], {11'd5, 11'd4, 11'd3, 11'd2, 11'd1});
    chk("single_rdy_in_write", wr_rdy[0], 0);
    @(negedge clk);
    chk("single_count", patch_count, 1);
    chk("single_busy", busy, 1);

    // Back-pressure over 3 more patches (addresses 1..3 in this frame).
    clear_log();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < PS; k++) begin
        idle($urandom_range(0, 2));
        send(DW'(100 + p*PS + k));
      end
    wait_writes(3);
    for (int p = 0; p < 3; p++) begin
      chk("bp_addr", wr_addr[p], 64'(p + 1));
      chk("bp_data", wr_data[p], pack(100 + p*PS));
      chk("bp_rdy_in_write", wr_rdy[p], 0);
    end

    // Full frame from a fresh reset.
    do_reset(2);
    clear_log();
    pulse_start();
    for (int i = 0; i < NP*PS; i++) send(DW'(i));
    wait_writes(NP);
    for (int p = 0; p < NP; p++) begin
      chk("frame_addr", wr_addr[p], 64'(p));
      chk("frame_data", wr_data[p], pack(p*PS));
    end
    chk("frame_last_addr", wr_addr[NP-1], 493);
    @(negedge clk);
    chk("frame_done", done, 1);
    chk("frame_busy", busy, 0);
    chk("frame_count", patch_count, 494);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 11'h7ff;
    repeat (3) begin
      @(negedge clk);
      chk("done_no_ready", in_ready, 0);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    chk("done_no_extra_write", wr_addr.size(), NP);
    chk("done_held", done, 1);
    chk("done_count_held", patch_count, 494);

    // start in DONE clears count and done.
    pulse_start();
    @(negedge clk);
    chk("restart_count", patch_count, 0);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);

    // Reset mid-patch: partial patch discarded.
    clear_log();
    for (int i = 0; i < 3; i++) send(DW'(200 + i));
    do_reset(1);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", patch_count, 0);
    @(posedge clk); #1;
    pulse_start();
    for (int i = 0; i < PS; i++) send(DW'(300 + i));
    wait_writes(1);
    chk("midrst_writes", wr_addr.size(), 1);
    chk("midrst_addr", wr_addr[0], 0);
    chk("midrst_data", wr_data[0], pack(300));

    // start while busy is ignored.
    do_reset(2);
    clear_log();
    pulse_start();
    send(11'd400); send(11'd401);
    pulse_start();
    for (int i = 2; i < PS; i++) send(DW'(400 + i));
    wait_writes(1);
    chk("busy_start_addr", wr_addr[0], 0);
    chk("busy_start_data", wr_data[0], pack(400));
    @(negedge clk);
    chk("busy_start_count", patch_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
